rtp_result_collector: RTL
=========================

# rtp_result_collector

Parametrised result-collection stage for the ray-tracing processor (RTP). It merges per-ray results (ray id, hitT) from NUM_CH traversal/intersection channels into one ordered output stream through a round-robin arbiter and a FIFO. It tracks per-channel completion and raises a single sticky `all_finish`. It also provides the synthesizable cycle counter and hit counter that the top-level previously measured only in simulation.

## Interface
Parameters:
- NUM_CH, 2, number of RTP result channels (1..8)
- ID_W, 32, ray id width
- T_W, 32, hitT width (IEEE-754 single)
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)
- CNT_W, 64, width of `total_cycle` and `hit_count`
- MISS_T, 32'h7F800000, hitT value meaning "no hit" (+inf)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  per-channel result valid
- in_ready  out  NUM_CH  per-channel accept (grant)
- in_ray_id  in  NUM_CH*ID_W  channel i at bits [i*ID_W +: ID_W]
- in_hitT  in  NUM_CH*T_W  channel i at bits [i*T_W +: T_W]
- ch_finish  in  NUM_CH  channel has issued its last result (pulse or level)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_ray_id  out  ID_W  head ray id
- out_hitT  out  T_W  head hitT
- out_ch  out  max(1,$clog2(NUM_CH))  source channel of head
- all_finish  out  1  sticky: all channels finished and stream drained
- total_cycle  out  CNT_W  cycles from reset release to `all_finish`
- hit_count  out  CNT_W  accepted results with hitT ≠ MISS_T

## Operation
- Arbiter: round-robin over channels with `in_valid` set. The search starts at `rr_ptr`. At most one grant per cycle, and only when the FIFO is not full. `in_ready[i]` = grant[i], combinational from `in_valid`, `rr_ptr`, and full. On a grant to channel g, `rr_ptr` ← (g+1) mod NUM_CH. With no grant, `rr_ptr` holds.
- Handshake: a transfer occurs when `in_valid[i] && in_ready[i]`. Channels hold valid and data stable until granted.
- FIFO: entries are {ch, ray_id, hitT}. Writes occur on a transfer. Reads occur on `out_valid && out_ready`. `out_*` are driven combinationally from the head entry (show-ahead). Full is evaluated before the same-cycle pop: when full, no grant is given even if a pop occurs. When empty, a write is not bypassed to the output.
- Occupancy counter is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Finish tracking: `fin_seen[i]` is set on `ch_finish[i]` and cleared only by reset.
- `all_finish` is set when all `fin_seen` bits are set (including bits set this cycle), the FIFO is empty, and `in_valid` is all zero. It is then sticky until reset.
- `total_cycle` increments every cycle while `all_finish` is 0, and freezes once set. It saturates at 2^CNT_W−1.
- `hit_count` increments on each transfer whose hitT ≠ MISS_T, and saturates. A transfer arriving after `all_finish` is still enqueued and counted (protocol error, not blocked).

## Timing
- Reset values: in_ready=0, out_valid=0, out_ray_id=0, out_hitT=0, out_ch=0, all_finish=0, total_cycle=0, hit_count=0, rr_ptr=0, FIFO empty, fin_seen=0.
- First cycle after reset deassert: total_cycle=0. It reads N after N further clock edges.
- Input-to-output latency: transfer at edge k gives out_valid=1 with that entry after edge k (visible in cycle k+1 if the FIFO was empty).
- Throughput: one result in and one out per cycle sustained when out_ready=1 and FIFO not full.
- `all_finish` rises on the edge where its condition first holds. total_cycle shows its final value on that same cycle.
- Reset mid-operation flushes the FIFO, counters, and finish state in one cycle. In-flight data is discarded.
- `ch_finish` and a transfer in the same cycle on the same channel: the result is accepted and finish is recorded. `all_finish` still waits for the FIFO to drain.

## Test plan
- NUM_CH=2, both valid continuously with ids 0x10/0x20, out_ready=1 → output ch order 0,1,0,1…, one per cycle, hit_count increments per non-MISS_T hitT.
- FIFO_DEPTH=8, out_ready=0, ch0 streams 10 results → exactly 8 accepted, in_ready[0]=0 afterward. Raise out_ready → ids emerge in order, accepts resume only once not full.
- Send hitT values {0x3F800000, 0x7F800000, 0x40000000} → hit_count=2.
- ch_finish on ch1 at cycle 5, on ch0 at cycle 12 with 3 entries queued and out_ready=1 → all_finish rises when the FIFO empties. total_cycle freezes at that cycle count and stays unchanged 20 cycles later.
- Assert reset for one cycle with the FIFO half full and all_finish=1 → all outputs return to reset values next cycle and total_cycle restarts from 0.
- NUM_CH=4, channels 1 and 3 valid, rr_ptr starting at 0 → grants alternate 1,3,1,3. Channel 2 joining after a grant to 1 is granted before 3.

Source files
------------

// File: rtl/rtp_result_collector.sv
// Merges per-channel ray results into one ordered stream through a round-robin arbiter and a show-ahead FIFO.
// Also tracks channel completion (sticky all_finish) and keeps saturating cycle and hit counters.
module rtp_result_collector #(
   parameter int NUM_CH = 2,
   parameter int ID_W = 32,
   parameter int T_W = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W = 64,
   parameter logic [T_W-1:0] MISS_T = 32'h7F800000,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      in_valid,
   output logic [NUM_CH-1:0]      in_ready,
   input  logic [NUM_CH*ID_W-1:0] in_ray_id,
   input  logic [NUM_CH*T_W-1:0]  in_hitT,
   input  logic [NUM_CH-1:0]      ch_finish,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ID_W-1:0]        out_ray_id,
   output logic [T_W-1:0]         out_hitT,
   output logic [CH_W-1:0]        out_ch,
   output logic                   all_finish,
   output logic [CNT_W-1:0]       total_cycle,
   output logic [CNT_W-1:0]       hit_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [ID_W-1:0] ray_id;
      logic [T_W-1:0]  hit_t;
   } entry_t;

   entry_t            mem_q [FIFO_DEPTH];
   entry_t            mem_d [FIFO_DEPTH];
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_any;
   logic [NUM_CH-1:0] grant;
   logic              full, push, pop;
   logic [ID_W-1:0]   grant_ray_id;
   logic [T_W-1:0]    grant_hit_t;
   logic [NUM_CH-1:0] fin_seen_q, fin_seen_d;
   logic              all_finish_q, all_finish_d;
   logic [CNT_W-1:0]  total_cycle_q, total_cycle_d;
   logic [CNT_W-1:0]  hit_count_q, hit_count_d;

   assign full = (count_q == (PTR_W+1)'(FIFO_DEPTH));

   // Fullness is judged before any same-cycle pop, so a full FIFO never grants.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      if (!reset && !full) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_any && in_valid[idx]) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(idx);
            end
         end
      end
      grant[grant_idx] = grant_any;
   end

   assign in_ready     = grant;
   assign grant_ray_id = in_ray_id[grant_idx*ID_W +: ID_W];
   assign grant_hit_t  = in_hitT[grant_idx*T_W +: T_W];
   assign push         = grant_any;
   assign pop          = (count_q != '0) && out_ready;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any)
         rr_ptr_d = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{ch: grant_idx, ray_id: grant_ray_id, hit_t: grant_hit_t};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   // Late transfers after all_finish are still counted; only the cycle counter freezes.
   always_comb begin
      fin_seen_d    = fin_seen_q | ch_finish;
      all_finish_d  = all_finish_q | ((&fin_seen_d) && (count_q == '0) && (in_valid == '0));
      total_cycle_d = total_cycle_q;
      hit_count_d   = hit_count_q;
      if (!all_finish_q && (total_cycle_q != '1)) total_cycle_d = total_cycle_q + 1'b1;
      if (push && (grant_hit_t != MISS_T) && (hit_count_q != '1)) hit_count_d = hit_count_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rr_ptr_q      <= '0;
         fin_seen_q    <= '0;
         all_finish_q  <= 1'b0;
         total_cycle_q <= '0;
         hit_count_q   <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rr_ptr_q      <= rr_ptr_d;
         fin_seen_q    <= fin_seen_d;
         all_finish_q  <= all_finish_d;
         total_cycle_q <= total_cycle_d;
         hit_count_q   <= hit_count_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign head        = mem_q[rd_ptr_q];
   assign out_valid   = (count_q != '0);
   assign out_ray_id  = out_valid ? head.ray_id : '0;
   assign out_hitT    = out_valid ? head.hit_t : '0;
   assign out_ch      = out_valid ? head.ch : '0;
   assign all_finish  = all_finish_q;
   assign total_cycle = total_cycle_q;
   assign hit_count   = hit_count_q;

endmodule
